// File: rtl/pixel_downloader.sv
// pixel_downloader: write-direction pixel DMA.
// Pops 32-bit words from a non-showahead pixel FIFO, packs them into 256-bit
// beats (optionally expanding 3-byte pixels to 4 bytes) and writes them to
// memory over an Avalon-MM write-only master.
// Optional feature macro: WRITE_RESP_CHECK_EN (write-response check with timeout).
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for enable and enough FIFO fill to start a beat
// S_COLLECT   | popping N words from the FIFO into the slot registers
// S_WRITE     | holding the beat on the bus until the slave accepts it
// S_WAIT_RESP | waiting for the write response (WRITE_RESP_CHECK_EN only)
module pixel_downloader #(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [32:0]  avl_mm_addr,
    output logic         avl_mm_write,
    output logic [255:0] avl_mm_writedata,
    output logic [31:0]  avl_mm_byteenable,
    input  logic         avl_mm_waitrequest,
    input  logic         avl_mm_writeresponsevalid,
    input  logic [1:0]   avl_mm_response,
    output logic         pix_fifo_read,
    input  logic [31:0]  pix_fifo_data,
    input  logic         pix_fifo_empty,
    input  logic [9:0]   pix_fifo_usedw,
    input  logic         enable,
    input  logic         word_mode,
    input  logic [31:0]  base_address,
    input  logic [31:0]  total_size,
    input  logic [9:0]   pix_fifo_threshold,
    input  logic         transform_data,
    output logic         write_error_w,
    output logic         frame_done,
    output logic         active
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COLLECT   = 2'd1,
        S_WRITE     = 2'd2,
        S_WAIT_RESP = 2'd3
    } state_t;

    state_t      state_q;
    logic        enable_q;
    logic        err_q;
    logic        xform_q;
    logic        wmode_q;
    logic        frame_done_q;
    logic        rd_pend_q;
    logic [3:0]  issued_q;
    logic [3:0]  captured_q;
    logic [31:0] base_q;
    logic [31:0] cur_q;
    logic [31:0] slot_q [8];

`ifdef WRITE_RESP_CHECK_EN
    logic        wr_err_q;
    logic [15:0] tmo_q;
`endif

    logic [3:0]   n_start_d;
    logic [3:0]   n_beat_d;
    logic [31:0]  next_addr_d;
    logic [31:0]  wrap_addr_d;
    logic         enable_rise;
    logic         start_beat;
    logic         rd_d;
    logic [191:0] pix_vec;
    logic [255:0] wdata_d;

    // Beat size for a beat about to start (live input) and the beat in flight (latched).
    assign n_start_d   = transform_data ? 4'd6 : 4'd8;
    assign n_beat_d    = xform_q ? 4'd6 : 4'd8;
    assign next_addr_d = cur_q + (wmode_q ? 32'd1 : 32'd32);
    assign wrap_addr_d = base_q + total_size;
    assign enable_rise = enable & ~enable_q;
    assign start_beat  = (state_q == S_IDLE) & enable & ~err_q
                       & (pix_fifo_usedw >= pix_fifo_threshold)
                       & (pix_fifo_usedw >= {6'd0, n_start_d});
    assign rd_d        = (state_q == S_COLLECT) & (issued_q < n_beat_d) & ~pix_fifo_empty;

    assign pix_fifo_read     = rd_d;
    assign avl_mm_write      = (state_q == S_WRITE);
    assign avl_mm_addr       = {1'b0, cur_q};
    assign avl_mm_writedata  = wdata_d;
    assign avl_mm_byteenable = '1;
    assign frame_done        = frame_done_q;
    assign active            = (state_q != S_IDLE);

`ifdef WRITE_RESP_CHECK_EN
    assign write_error_w = wr_err_q;
`else
    logic unused_resp;
    assign write_error_w = 1'b0;
    assign unused_resp   = ^{avl_mm_writeresponsevalid, avl_mm_response, RESP_TIMEOUT[0]};
`endif

    // Beat packing: straight word copy, or 24-bit pixels spread into 32-bit lanes with a zero top byte.
    always_comb begin
        pix_vec = {slot_q[5], slot_q[4], slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
        wdata_d = '0;
        if (xform_q) begin
            for (int p = 0; p < 8; p++) begin
                wdata_d[32*p +: 24] = pix_vec[24*p +: 24];
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                wdata_d[32*k +: 32] = slot_q[k];
            end
        end
    end

    // Main FSM: collection, bus hold, address advance/wrap, error latch and enable-edge reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            enable_q     <= 1'b0;
            err_q        <= 1'b0;
            xform_q      <= 1'b0;
            wmode_q      <= 1'b0;
            frame_done_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            issued_q     <= '0;
            captured_q   <= '0;
            base_q       <= '0;
            cur_q        <= '0;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= '0;
            end
`ifdef WRITE_RESP_CHECK_EN
            wr_err_q     <= 1'b0;
            tmo_q        <= '0;
`endif
        end else begin
            enable_q     <= enable;
            frame_done_q <= 1'b0;
            rd_pend_q    <= rd_d;
`ifdef WRITE_RESP_CHECK_EN
            wr_err_q     <= 1'b0;
`endif
            if (!enable) begin
                err_q <= 1'b0;
            end
            if (rd_d) begin
                issued_q <= issued_q + 4'd1;
            end
            // FIFO is non-showahead: data for a pop is on the bus one cycle later.
            if (rd_pend_q) begin
                slot_q[captured_q[2:0]] <= pix_fifo_data;
                captured_q              <= captured_q + 4'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_beat) begin
                        state_q    <= S_COLLECT;
                        xform_q    <= transform_data;
                        wmode_q    <= word_mode;
                        issued_q   <= '0;
                        captured_q <= '0;
                    end
                end
                S_COLLECT: begin
                    if (captured_q == n_beat_d) begin
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!avl_mm_waitrequest) begin
                        if (next_addr_d == wrap_addr_d) begin
                            cur_q        <= base_q;
                            frame_done_q <= 1'b1;
                        end else begin
                            cur_q <= next_addr_d;
                        end
`ifdef WRITE_RESP_CHECK_EN
                        tmo_q   <= 16'(RESP_TIMEOUT - 1);
                        state_q <= S_WAIT_RESP;
`else
                        state_q <= S_IDLE;
`endif
                    end
                end
`ifdef WRITE_RESP_CHECK_EN
                S_WAIT_RESP: begin
                    if (avl_mm_writeresponsevalid) begin
                        if (avl_mm_response != 2'b00) begin
                            wr_err_q <= 1'b1;
                            err_q    <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end else if (tmo_q == '0) begin
                        wr_err_q <= 1'b1;
                        err_q    <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q - 16'd1;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase

            // A fresh enable edge restarts the frame and takes priority over an accept's advance.
            if (enable_rise) begin
                base_q <= base_address;
                cur_q  <= base_address;
            end
        end
    end

endmodule
